// File: rtl/axis_pkt_m.sv
// axis_pkt_m: AXI-Stream packet master with an internal first-word-fall-through FIFO.
// The producer pushes words into the FIFO. A rising edge on send then streams pkt_len beats
// on AXIS. tlast marks the final beat, and a one-cycle finish pulse follows the last handshake.
//
// Ports:
//   aclk, areset         clock, synchronous active-high reset
//   wr_en, wr_data       FIFO write (dropped while wr_full)
//   wr_full, fifo_level  FIFO status (registered)
//   send, pkt_len        packet start (rising edge) and length sampled on that edge
//   busy                 packet in progress
//   tvalid, tready,
//   tdata, tlast         AXIS master interface
//   finish               one-cycle pulse after the last handshake
module axis_pkt_m #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LEN_W      = 8
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          send,
    input  logic [LEN_W-1:0]              pkt_len,
    output logic                          busy,
    input  logic                          tready,
    output logic                          tvalid,
    output logic [DATA_W-1:0]             tdata,
    output logic                          tlast,
    output logic                          finish
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              push, pop, fifo_empty;

    // Packet control
    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              send_q;
    logic              send_edge;

    assign fifo_empty = (count_q == '0);
    assign wr_full    = (count_q == FULL_CNT);
    assign fifo_level = count_q;
    assign send_edge  = send & ~send_q;

    // Full check uses the registered count, so a same-cycle pop never frees room for a write.
    assign push = wr_en & ~wr_full;
    assign pop  = tvalid & tready;

    // Head entry is shown only while valid so tdata is 0 out of reset.
    assign tdata = tvalid ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= StIdle;
            len_q   <= '0;
            cnt_q   <= '0;
            send_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            send_q  <= send;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        busy    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Zero-length requests are ignored outright.
                if (send_edge && (pkt_len != '0)) begin
                    len_d   = pkt_len;
                    cnt_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                busy   = 1'b1;
                tvalid = ~fifo_empty;
                tlast  = tvalid && (cnt_q == len_q - LEN_W'(1));
                if (tvalid && tready) begin
                    // Counter holds at len-1 on the final beat instead of overflowing.
                    if (tlast) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            StDone: begin
                finish  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_axis_pkt_m.sv
module tb_axis_pkt_m;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int LEN_W  = 8;

    logic              aclk = 1'b0;
    logic              areset;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_full;
    logic [4:0]        fifo_level;
    logic              send;
    logic [LEN_W-1:0]  pkt_len;
    logic              busy;
    logic              tready;
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              finish;

    axis_pkt_m #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(DEPTH),
        .LEN_W     (LEN_W)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_full   (wr_full),
        .fifo_level(fifo_level),
        .send      (send),
        .pkt_len   (pkt_len),
        .busy      (busy),
        .tready    (tready),
        .tvalid    (tvalid),
        .tdata     (tdata),
        .tlast     (tlast),
        .finish    (finish)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] sb[$];  // expected AXIS data in order
    int mdl_level = 0;

    typedef struct {
        int          nwr;      // words written before send
        logic [31:0] base;     // first data word
        int          exp_pre;  // expected level after the writes
        bit          exp_full;
        int          plen;
        logic [7:0]  rdy;      // tready pattern, bit index = cycle % 8
        int          late_at;  // cycle at which extra words are written (-1: none)
        int          late_n;
        bit          exp_gap;  // tvalid expected to drop mid-packet
        int          exp_post; // expected level after the packet
    } vec_t;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic write_word(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        if (mdl_level < DEPTH) begin
            sb.push_back(d);
            mdl_level++;
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_send(input int len);
        pkt_len = LEN_W'(len);
        send    = 1'b1;
        tick();
        send    = 1'b0;
        pkt_len = '0;  // length must have been latched on the edge
    endtask

    task automatic run_packet(input int plen, input logic [7:0] rdy, input int late_at,
                              input int late_n, input logic [31:0] late_base, output bit gap);
        int beats = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [31:0] held = '0;
        gap = 0;
        while (beats < plen && cyc < 100) begin
            tready = rdy[cyc % 8];
            if (late_at >= 0 && cyc >= late_at && cyc < late_at + late_n) begin
                wr_en   = 1'b1;
                wr_data = late_base + 32'(cyc - late_at);
                if (mdl_level < DEPTH) begin
                    sb.push_back(wr_data);
                    mdl_level++;
                end
            end else begin
                wr_en = 1'b0;
            end
            check("busy_in_pkt", 64'(busy), 64'(1));
            if (stalled) begin
                check("stall_valid_hold", 64'(tvalid), 64'(1));
                check("stall_data_hold", 64'(tdata), 64'(held));
            end
            if (tvalid) begin
                check("tdata", 64'(tdata), 64'(sb[0]));
                check("tlast", 64'(tlast), 64'(beats == plen - 1));
                if (tready) begin
                    void'(sb.pop_front());
                    mdl_level--;
                    beats++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held    = tdata;
                end
            end else begin
                check("tlast_no_valid", 64'(tlast), 64'(0));
                if (beats > 0) gap = 1;
            end
            tick();
            cyc++;
        end
        wr_en  = 1'b0;
        tready = 1'b0;
        if (beats < plen) begin
            errors++;
            $display("FAIL packet_timeout: got %0d beats required %0d", beats, plen);
        end
        check("finish_pulse", 64'(finish), 64'(1));
        check("busy_done", 64'(busy), 64'(0));
        check("tvalid_done", 64'(tvalid), 64'(0));
        tick();
        check("finish_one_cycle", 64'(finish), 64'(0));
        check("tvalid_idle", 64'(tvalid), 64'(0));
        check("tlast_idle", 64'(tlast), 64'(0));
    endtask

    vec_t vecs[6];

    initial begin
        bit gap;

        vecs[0] = '{4,  32'hA0,  4,  0, 4,  8'hFF,       -1, 0, 0, 0};
        vecs[1] = '{4,  32'hA0,  4,  0, 4,  8'b1001_1001, -1, 0, 0, 0};
        vecs[2] = '{2,  32'hA0,  2,  0, 4,  8'hFF,        5, 2, 1, 0};
        vecs[3] = '{6,  32'hB0,  6,  0, 3,  8'hFF,       -1, 0, 0, 3};
        vecs[4] = '{0,  32'h0,   3,  0, 3,  8'b0110_1011, -1, 0, 0, 0};
        vecs[5] = '{18, 32'h100, 16, 1, 16, 8'hFF,       -1, 0, 0, 0};

        areset  = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        send    = 1'b0;
        pkt_len = '0;
        tready  = 1'b0;
        tick();
        tick();
        areset = 1'b0;

        check("rst_tvalid", 64'(tvalid), 64'(0));
        check("rst_tlast", 64'(tlast), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_finish", 64'(finish), 64'(0));
        check("rst_full", 64'(wr_full), 64'(0));
        check("rst_level", 64'(fifo_level), 64'(0));
        check("rst_tdata", 64'(tdata), 64'(0));

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vecs[v].nwr; i++) begin
                write_word(vecs[v].base + 32'(i));
            end
            check("pre_level", 64'(fifo_level), 64'(vecs[v].exp_pre));
            check("pre_full", 64'(wr_full), 64'(vecs[v].exp_full));
            check("idle_no_valid", 64'(tvalid), 64'(0));
            pulse_send(vecs[v].plen);
            run_packet(vecs[v].plen, vecs[v].rdy, vecs[v].late_at, vecs[v].late_n,
                       vecs[v].base + 32'(vecs[v].nwr), gap);
            check("gap", 64'(gap), 64'(vecs[v].exp_gap));
            check("post_level", 64'(fifo_level), 64'(vecs[v].exp_post));
        end

        // Zero-length edge is ignored.
        write_word(32'hD0);
        write_word(32'hD1);
        write_word(32'hD2);
        pulse_send(0);
        check("len0_busy", 64'(busy), 64'(0));
        check("len0_tvalid", 64'(tvalid), 64'(0));
        tick();
        check("len0_finish", 64'(finish), 64'(0));
        check("len0_level", 64'(fifo_level), 64'(3));

        // Second edge while busy is ignored and not queued.
        pulse_send(2);
        tick();
        send    = 1'b1;
        pkt_len = 8'd5;
        tick();
        run_packet(2, 8'hFF, -1, 0, 32'h0, gap);
        for (int i = 0; i < 3; i++) begin
            check("no_requeue_busy", 64'(busy), 64'(0));
            check("no_requeue_valid", 64'(tvalid), 64'(0));
            check("no_requeue_finish", 64'(finish), 64'(0));
            tick();
        end
        send = 1'b0;
        check("leftover_level", 64'(fifo_level), 64'(1));

        // Reset in the middle of a packet.
        for (int i = 0; i < 4; i++) write_word(32'hE0 + 32'(i));
        pulse_send(4);
        tready = 1'b1;
        check("pre_rst_data", 64'(tdata), 64'(sb[0]));
        tick();
        check("beat2_valid", 64'(tvalid), 64'(1));
        tready = 1'b0;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        sb.delete();
        mdl_level = 0;
        check("abort_tvalid", 64'(tvalid), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_level", 64'(fifo_level), 64'(0));
        check("abort_finish", 64'(finish), 64'(0));
        tick();
        check("abort_finish_later", 64'(finish), 64'(0));

        for (int i = 0; i < 4; i++) write_word(32'hC0 + 32'(i));
        pulse_send(4);
        run_packet(4, 8'hFF, -1, 0, 32'h0, gap);
        check("after_rst_level", 64'(fifo_level), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
